// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: rotate-left, rotate-right, ping-pong and flash patterns
// advanced by prescaler ticks, with a pending-mode register applied on the next step.
module led_seq_ctrl #(
    parameter int NB_LEDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    input  logic               i_run,
    input  logic [1:0]         i_mode_req,
    input  logic               i_mode_load,
    input  logic               i_clear,
    output logic [NB_LEDS-1:0] o_leds,
    output logic [2:0]         o_state,
    output logic               o_pending,
    output logic               o_wrap
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_ROTL  = 3'b001,
        S_ROTR  = 3'b010,
        S_PP    = 3'b011,
        S_FLASH = 3'b100
    } state_t;

    localparam logic [NB_LEDS-1:0] SEED_LSB = NB_LEDS'(1);
    localparam logic [NB_LEDS-1:0] SEED_MSB = {1'b1, {(NB_LEDS-1){1'b0}}};
    localparam logic [NB_LEDS-1:0] ALL_ONES = '1;

    state_t     state;
    logic [1:0] pend_mode;
    logic       dir_left;

    logic       step;
    logic       apply_valid;
    logic [1:0] apply_mode;
    logic       state_legal;

    // A load in the same cycle as a step is applied immediately, bypassing the register.
    assign step        = i_tick & i_run;
    assign apply_valid = i_mode_load | o_pending;
    assign apply_mode  = i_mode_load ? i_mode_req : pend_mode;
    assign state_legal = (state inside {S_IDLE, S_ROTL, S_ROTR, S_PP, S_FLASH});
    assign o_state     = state;

    // NOTE: every register here is written with <= so all next-state terms read pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            o_leds    <= '0;
            o_pending <= 1'b0;
            o_wrap    <= 1'b0;
            dir_left  <= 1'b1;
            pend_mode <= 2'b00;
        end else if (i_clear) begin
            state     <= S_IDLE;
            o_leds    <= '0;
            o_pending <= 1'b0;
            o_wrap    <= 1'b0;
            dir_left  <= 1'b1;
        end else begin
            o_wrap <= 1'b0;
            if (i_mode_load) begin
                pend_mode <= i_mode_req;
                o_pending <= 1'b1;
            end

            if (!state_legal) begin
                state  <= S_IDLE;
                o_leds <= '0;
            end else if (step) begin
                if (apply_valid) begin
                    o_pending <= 1'b0;
                    case (apply_mode)
                        2'b00: begin
                            state  <= S_ROTL;
                            o_leds <= SEED_LSB;
                        end
                        2'b01: begin
                            state  <= S_ROTR;
                            o_leds <= SEED_MSB;
                        end
                        2'b10: begin
                            state    <= S_PP;
                            o_leds   <= SEED_LSB;
                            dir_left <= 1'b1;
                        end
                        default: begin
                            state  <= S_FLASH;
                            o_leds <= ALL_ONES;
                        end
                    endcase
                end else begin
                    case (state)
                        S_IDLE: begin
                            state  <= S_ROTL;
                            o_leds <= SEED_LSB;
                        end
                        S_ROTL: begin
                            o_leds <= {o_leds[NB_LEDS-2:0], o_leds[NB_LEDS-1]};
                            o_wrap <= o_leds[NB_LEDS-1];
                        end
                        S_ROTR: begin
                            o_leds <= {o_leds[0], o_leds[NB_LEDS-1:1]};
                            o_wrap <= o_leds[0];
                        end
                        S_PP: begin
                            // Direction flips on the edge the lit bit lands on an end.
                            if (dir_left) begin
                                o_leds <= o_leds << 1;
                                if (o_leds[NB_LEDS-2]) begin
                                    dir_left <= 1'b0;
                                    o_wrap   <= 1'b1;
                                end
                            end else begin
                                o_leds <= o_leds >> 1;
                                if (o_leds[1]) begin
                                    dir_left <= 1'b1;
                                    o_wrap   <= 1'b1;
                                end
                            end
                        end
                        S_FLASH: begin
                            o_leds <= ~o_leds;
                            o_wrap <= &o_leds;
                        end
                        default: begin
                            state  <= S_IDLE;
                            o_leds <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus randomized traffic
// compared against a position/phase based reference model.
module tb_led_seq_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_tick, i_run, i_mode_load, i_clear;
    logic [1:0]   i_mode_req;
    logic [N-1:0] o_leds;
    logic [2:0]   o_state;
    logic         o_pending, o_wrap;

    int total = 0;
    int bad   = 0;

    // Reference model: mode number, lit position, ping-pong direction, flash phase.
    int m_st, m_pos, m_dir, m_pmode;
    bit m_on, m_pend, m_wrap;

    led_seq_ctrl #(.NB_LEDS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (i_tick),
        .i_run      (i_run),
        .i_mode_req (i_mode_req),
        .i_mode_load(i_mode_load),
        .i_clear    (i_clear),
        .o_leds     (o_leds),
        .o_state    (o_state),
        .o_pending  (o_pending),
        .o_wrap     (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_leds();
        case (m_st)
            1, 2, 3: return N'(1 << m_pos);
            4:       return m_on ? {N{1'b1}} : '0;
            default: return '0;
        endcase
    endfunction

    function automatic void m_reset();
        m_st = 0; m_pos = 0; m_dir = 1; m_on = 0;
        m_pend = 0; m_pmode = 0; m_wrap = 0;
    endfunction

    function automatic void m_edge(bit tick, bit run, int mode, bit load, bit clr);
        m_wrap = 0;
        if (clr) begin
            m_st = 0; m_pend = 0; m_dir = 1; m_pos = 0; m_on = 0;
            return;
        end
        if (load) begin
            m_pend = 1; m_pmode = mode;
        end
        if (!(tick && run)) return;
        if (m_pend) begin
            m_pend = 0;
            case (m_pmode)
                0: begin m_st = 1; m_pos = 0; end
                1: begin m_st = 2; m_pos = N - 1; end
                2: begin m_st = 3; m_pos = 0; m_dir = 1; end
                default: begin m_st = 4; m_on = 1; end
            endcase
            return;
        end
        case (m_st)
            0: begin m_st = 1; m_pos = 0; end
            1: begin m_wrap = (m_pos == N - 1); m_pos = (m_pos + 1) % N; end
            2: begin m_wrap = (m_pos == 0); m_pos = (m_pos + N - 1) % N; end
            3: begin
                m_pos += m_dir;
                if (m_pos == N - 1 || m_pos == 0) begin
                    m_dir  = -m_dir;
                    m_wrap = 1;
                end
            end
            default: begin m_wrap = m_on; m_on = !m_on; end
        endcase
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".leds"},    32'(o_leds),    32'(m_leds()));
        check({tag, ".state"},   32'(o_state),   32'(m_st));
        check({tag, ".pending"}, 32'(o_pending), 32'(m_pend));
        check({tag, ".wrap"},    32'(o_wrap),    32'(m_wrap));
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model, sample #1 later.
    task automatic cyc(input string tag, input bit tick, input bit run, input logic [1:0] mode,
                       input bit load, input bit clr);
        i_tick = tick; i_run = run; i_mode_req = mode; i_mode_load = load; i_clear = clr;
        @(posedge clk);
        m_edge(tick, run, int'(mode), load, clr);
        #1;
        compare_all(tag);
    endtask

    logic [N-1:0] exp32 [5];
    logic [N-1:0] exp33 [8];

    initial begin
        exp32 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp33 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        m_reset();

        // Inputs toggling during reset must be ignored.
        rst = 1'b1;
        i_tick = 1'b1; i_run = 1'b1; i_mode_req = 2'b11; i_mode_load = 1'b1; i_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;

        // Rotate-left from IDLE, wrap on the fifth tick.
        for (int i = 0; i < 5; i++) begin
            cyc("r32", 1, 1, 2'b00, 0, 0);
            check("r32.const_leds", 32'(o_leds), 32'(exp32[i]));
            check("r32.const_wrap", 32'(o_wrap), (i == 4) ? 32'd1 : 32'd0);
        end
        check("r32.const_state", 32'(o_state), 32'd1);

        // Ping-pong load then eight ticks.
        cyc("r33.load", 0, 1, 2'b10, 1, 0);
        check("r33.const_pending", 32'(o_pending), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc("r33", 1, 1, 2'b00, 0, 0);
            check("r33.const_leds", 32'(o_leds), 32'(exp33[i]));
            check("r33.const_wrap", 32'(o_wrap), (i == 3 || i == 6) ? 32'd1 : 32'd0);
        end

        // Load and tick in the same cycle apply the new mode at once.
        cyc("r34.apply", 1, 1, 2'b01, 1, 0);
        check("r34.const_leds", 32'(o_leds), 32'b1000);
        check("r34.const_state", 32'(o_state), 32'd2);
        cyc("r34.next", 1, 1, 2'b00, 0, 0);
        check("r34.const_next", 32'(o_leds), 32'b0100);

        // Frozen while i_run=0; load is held until the first real step.
        cyc("r35.frz", 1, 0, 2'b00, 0, 0);
        cyc("r35.frz", 1, 0, 2'b11, 1, 0);
        cyc("r35.frz", 1, 0, 2'b00, 0, 0);
        check("r35.const_frozen", 32'(o_leds), 32'b0100);
        check("r35.const_pending", 32'(o_pending), 32'd1);
        cyc("r35.apply", 1, 1, 2'b00, 0, 0);
        check("r35.const_ones", 32'(o_leds), 32'b1111);
        check("r35.const_state", 32'(o_state), 32'd4);
        cyc("r35.off", 1, 1, 2'b00, 0, 0);
        check("r35.const_zero", 32'(o_leds), 32'b0000);
        check("r35.const_wrap", 32'(o_wrap), 32'd1);

        // Clear beats a simultaneous tick and load while in ping-pong.
        cyc("r36.pp", 1, 1, 2'b10, 1, 0);
        cyc("r36.pp", 1, 1, 2'b00, 0, 0);
        cyc("r36.clr", 1, 1, 2'b11, 1, 1);
        check("r36.const_leds", 32'(o_leds), 32'd0);
        check("r36.const_state", 32'(o_state), 32'd0);
        check("r36.const_pending", 32'(o_pending), 32'd0);

        // Async reset mid-FLASH with a pending load outstanding.
        cyc("r36.fl", 1, 1, 2'b11, 1, 0);
        cyc("r36.pend", 0, 1, 2'b01, 1, 0);
        i_tick = 0; i_mode_load = 0;
        #2 rst = 1'b1;
        #1;
        check("async.leds",    32'(o_leds),    32'd0);
        check("async.state",   32'(o_state),   32'd0);
        check("async.pending", 32'(o_pending), 32'd0);
        check("async.wrap",    32'(o_wrap),    32'd0);
        m_reset();
        i_tick = 1; i_run = 1; i_mode_load = 1; i_mode_req = 2'b10;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("r30.first", 1, 1, 2'b00, 0, 0);
        check("r30.const_leds", 32'(o_leds), 32'b0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter NB_LEDS, default 4: width of LED pattern; legal range 2..16.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset rst, asynchronous, active-high.
REQ-004 i_tick  input  1  one-cycle step pulse from the prescaler counter; ignored unless high for the sampling edge.
REQ-005 i_run  input  1  level; 1 = advance pattern on ticks, 0 = freeze pattern.
REQ-006 i_mode_req  input  2  requested mode: 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 flash.
REQ-007 i_mode_load  input  1  one-cycle strobe capturing i_mode_req into the pending-mode register.
REQ-008 i_clear  input  1  synchronous return to IDLE.
REQ-009 o_leds  output  NB_LEDS  registered LED pattern.
REQ-010 o_state  output  3  registered FSM state code: IDLE=000, ROTL=001, ROTR=010, PP=011, FLASH=100.
REQ-011 o_pending  output  1  registered; 1 while a captured mode change awaits application.
REQ-012 o_wrap  output  1  registered one-cycle pulse marking a pattern cycle boundary.

Function
REQ-013 The block SHALL be a five-state FSM (IDLE, ROTL, ROTR, PP, FLASH) plus pending-mode register (2 bits + valid), PP direction flag, o_leds register.
REQ-014 Priority per edge: i_clear > tick processing > hold.
REQ-015 i_clear=1 SHALL force IDLE, o_leds=0, pending valid=0, direction=left, o_wrap=0 on that edge; i_mode_load in the same cycle is discarded.
REQ-016 i_mode_load=1 (no i_clear) SHALL capture i_mode_req and set pending valid; a later load before application overwrites the earlier one.
REQ-017 "Step" = i_tick=1 and i_run=1 at the sampling edge; ticks with i_run=0 SHALL be ignored in all states, outputs held.
REQ-018 Mode application: on a step with pending valid (including load in the same cycle, which uses the newly loaded value), the FSM SHALL enter the pending mode, load its seed pattern, clear pending valid; no shift occurs on that step and o_wrap=0.
REQ-019 Seeds: ROTL = bit0 only; ROTR = bit NB_LEDS-1 only; PP = bit0 only with direction=left; FLASH = all ones.
REQ-020 IDLE: a step with no pending mode SHALL enter ROTL with ROTL seed.
REQ-021 ROTL step: o_leds rotated left by one; when bit NB_LEDS-1 was set before the step, o_wrap=1 for that edge.
REQ-022 ROTR step: o_leds rotated right by one; when bit0 was set before the step, o_wrap=1.
REQ-023 PP step: single lit bit moves one position in current direction; on reaching bit NB_LEDS-1 (left) or bit0 (right) the direction flag SHALL toggle on that same edge and o_wrap=1; no bit ever leaves the vector.
REQ-024 FLASH step: o_leds inverted (all ones <-> all zeros); o_wrap=1 on ones-to-zeros transition.
REQ-025 Latency: o_leds, o_state, o_wrap SHALL update on the same edge that samples the step; o_pending updates on the edge that samples the load/application.
REQ-026 o_wrap SHALL be 0 on every edge without a qualifying step.
REQ-027 i_mode_load while i_run=0 SHALL be captured and held until the first step.
REQ-028 Unused state encodings SHALL recover to IDLE with o_leds=0 on the next edge.

Reset
REQ-029 rst=1 SHALL asynchronously force: state IDLE, o_leds=0, o_state=000, o_pending=0, o_wrap=0, direction=left, pending mode=00.
REQ-030 Reset asserted mid-pattern SHALL abort immediately; after release the first step follows REQ-020.
REQ-031 Inputs during rst SHALL be ignored; first capture is on the first edge after deassertion.

Verification (NB_LEDS=4)
REQ-032 Reset, i_run=1, 5 ticks -> o_leds 0001,0010,0100,1000,0001; o_wrap pulses only on 5th tick; o_state=001.
REQ-033 Load mode 10 in ROTL, run 8 ticks -> seed 0001 then 0010,0100,1000(wrap),0100,0010,0001(wrap),0010.
REQ-034 Load mode 01 and tick in same cycle -> o_leds=1000, o_state=010, o_pending=0, o_wrap=0; next tick -> 0100.
REQ-035 i_run=0 with 3 ticks and a load of mode 11 -> o_leds frozen, o_pending=1; i_run=1, tick -> o_leds=1111, o_state=100; next tick -> 0000 with o_wrap=1.
REQ-036 i_clear with simultaneous tick and load in PP -> o_leds=0000, o_state=000, o_pending=0; async rst mid-FLASH -> all outputs zero immediately without clock edge.
